// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus responder: access sizes, MMIO map
// and the request/response sequencing states.
package dbus_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    localparam logic [31:0] LED_ADDR = 32'h8000_0000;
    localparam logic [31:0] CNT_ADDR = 32'h8000_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/dbus_if.sv
// Load/store request channel plus response channel between the CPU core
// (master) and the data-bus responder (slave).
interface dbus_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dbus_lanes.sv
// Byte-lane steering for little-endian sub-word accesses: store byte
// enables and data replication, load lane extraction with sign/zero
// extension, and the misalignment flag.
module dbus_lanes
    import dbus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    // Per-lane enable and replicated store data; an illegal size enables nothing.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_en[gi] = (size == SZ_B) ? (addr_lo == 2'(gi)) :
                             (size == SZ_H) ? (addr_lo[1] == 1'(gi / 2)) :
                             (size == SZ_W);
        assign wdata_rep[gi*8 +: 8] = (size == SZ_B) ? store_data[7:0] :
                                      (size == SZ_H) ? store_data[(gi % 2)*8 +: 8] :
                                                       store_data[gi*8 +: 8];
    end

    assign shifted  = load_word >> {addr_lo, 3'b000};
    assign misalign = ((size == SZ_H) && addr_lo[0]) ||
                      ((size == SZ_W) && (addr_lo != 2'b00));

    // Move the addressed lane down to bit 0 and extend it to 32 bits.
    always_comb begin
        load_data = load_word;
        case (size)
            SZ_B: load_data = is_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/dbus_responder.sv
// Handshaked, wait-stated data-bus target: word RAM plus LED and
// free-running cycle-counter registers, one outstanding request at a time.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int RAM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
)
(
    input  logic       CLK100MHZ,
    input  logic       ck_rst,
    dbus_if.slave      bus,
    output logic [3:0] led
);

    localparam int          AW         = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_LIMIT  = 33'(RAM_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_reg, state_next;
    logic [3:0]  wcnt_reg, wcnt_next;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic [3:0]  led_reg;
    logic [31:0] cnt_reg;
    logic [31:0] ram_q_reg;

    logic [31:0] ram [RAM_WORDS];

    logic        accept;
    logic        exec;
    logic        hit_ram, hit_led, hit_cnt;
    logic        misalign;
    logic        acc_err;
    logic        wr_ok;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [AW-1:0] rd_idx;

    assign accept = (state_reg == IDLE) && bus.req_valid;
    assign exec   = (state_reg == EXEC);

    // Address decode and error classification of the latched request.
    assign hit_ram = ({1'b0, addr_reg} < RAM_LIMIT);
    assign hit_led = (addr_reg == LED_ADDR);
    assign hit_cnt = (addr_reg == CNT_ADDR);
    assign acc_err = (size_reg == SZ_X) || misalign || !(hit_ram || hit_led || hit_cnt);
    assign wr_ok   = exec && we_reg && !acc_err;

    assign load_word = hit_led ? {28'b0, led_reg} :
                       hit_cnt ? cnt_reg : ram_q_reg;

    dbus_lanes u_lanes (
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .addr_lo     (addr_reg[1:0]),
        .store_data  (wdata_reg),
        .load_word   (load_word),
        .byte_en     (byte_en),
        .wdata_rep   (wdata_rep),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    // State and wait-counter registers; reset abandons any request in flight.
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state_reg <= IDLE;
            wcnt_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    // Next-state logic: IDLE -> [WAIT x WAIT_STATES] -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : EXEC;
                    wcnt_next  = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (wcnt_reg == 4'd0) state_next = EXEC;
                else                  wcnt_next  = wcnt_reg - 4'd1;
            end
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the request on acceptance and the response at the end of EXEC.
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            we_reg    <= 1'b0;
            size_reg  <= 2'd0;
            uns_reg   <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                we_reg    <= bus.req_we;
                size_reg  <= bus.req_size;
                uns_reg   <= bus.req_unsigned;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
            end
            if (exec) begin
                rdata_reg <= (acc_err || we_reg) ? 32'd0 : load_data;
                err_reg   <= acc_err;
            end
        end
    end

    // LED register and cycle counter; a legal counter store clears it, beating the increment.
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            led_reg <= 4'd0;
            cnt_reg <= 32'd0;
        end else begin
            if (wr_ok && hit_led) led_reg <= wdata_reg[3:0];
            if (wr_ok && hit_cnt) cnt_reg <= 32'd0;
            else                  cnt_reg <= cnt_reg + 32'd1;
        end
    end

    // The RAM read is issued one cycle ahead so the word is registered by EXEC;
    // in IDLE the incoming address is used so zero wait states still work.
    assign rd_idx = (state_reg == IDLE) ? bus.req_addr[AW+1:2] : addr_reg[AW+1:2];

    // Byte-enabled block RAM with registered read; contents survive reset.
    always_ff @(posedge CLK100MHZ) begin
        if (wr_ok && hit_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[addr_reg[AW+1:2]][b*8 +: 8] <= wdata_rep[b*8 +: 8];
            end
        end
        ram_q_reg <= ram[rd_idx];
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = err_reg;
    assign led           = led_reg;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: a vector table of loads/stores
// checked through an expectation queue, plus hand sequences for response
// stalls, the cycle counter and reset during a wait state.
module tb_dbus_responder;

    localparam int WS = 3;

    logic       CLK100MHZ;
    logic       ck_rst;
    logic [3:0] led;
    int         cyc;
    int         checks;
    int         errors;

    dbus_if bus ();

    dbus_responder #(.RAM_WORDS(1024), .WAIT_STATES(WS)) dut (
        .CLK100MHZ (CLK100MHZ),
        .ck_rst    (ck_rst),
        .bus       (bus),
        .led       (led)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    initial cyc = 0;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_d;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs[22];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Issue one request, wait for its response, check it against the queued expectation.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e, input logic chk_d,
                          input int hold, input string nm,
                          output logic [31:0] got_d, output int vcyc);
        exp_t        e;
        int          n;
        logic        ready_bad;
        logic        stable_bad;
        logic [31:0] snap;
        e.rdata = exp_d; e.err = exp_e; e.chk_d = chk_d; e.name = nm;
        sb_q.push_back(e);
        got_d = 32'd0;
        vcyc  = 0;

        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge CLK100MHZ); #1; n++;
        end
        chk({nm, "_ready"}, {31'd0, bus.req_ready}, 32'd1);

        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge CLK100MHZ); #1;
        bus.req_valid = 1'b0;

        n = 0;
        ready_bad = 1'b0;
        while (!bus.rsp_valid && n < 50) begin
            if (bus.req_ready) ready_bad = 1'b1;
            @(posedge CLK100MHZ); #1; n++;
        end
        vcyc = cyc;
        chk({nm, "_latency"}, 32'(n), 32'(WS + 1));
        chk({nm, "_busy"}, {31'd0, ready_bad}, 32'd0);
        if (!bus.rsp_valid) begin
            void'(sb_q.pop_front());
            return;
        end

        snap = bus.rsp_rdata;
        stable_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK100MHZ); #1;
            if (!bus.rsp_valid || bus.rsp_rdata !== snap || bus.req_ready) stable_bad = 1'b1;
        end
        if (hold > 0) chk({nm, "_stable"}, {31'd0, stable_bad}, 32'd0);

        e = sb_q.pop_front();
        got_d = bus.rsp_rdata;
        if (e.chk_d) chk({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});

        bus.rsp_ready = 1'b1;
        @(posedge CLK100MHZ); #1;
        bus.rsp_ready = 1'b0;
        chk({nm, "_idle"}, {30'd0, bus.req_ready, bus.rsp_valid}, 32'h2);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d1, d2;
        int          v, v1, v2, vs;

        checks = 0;
        errors = 0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        ck_rst = 1'b0;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000001, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0,        32'h000000FF, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h000080FF, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80FFAB01, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1234AB01, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h00000012, 1'b0};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFFAB01, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h4000, 32'h0,      32'h0,        1'b1};
        vecs[15] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1};
        vecs[16] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1234AB01, 1'b0};
        vecs[18] = '{1'b1, 2'd2, 1'b0, 32'h80000000, 32'h5,  32'h0,        1'b0};
        vecs[19] = '{1'b0, 2'd2, 1'b0, 32'h80000000, 32'h0,  32'h00000005, 1'b0};
        vecs[20] = '{1'b1, 2'd2, 1'b0, 32'h80000001, 32'hF,  32'h0,        1'b1};
        vecs[21] = '{1'b0, 2'd2, 1'b0, 32'h80000008, 32'h0,  32'h0,        1'b1};

        // Reset state
        repeat (3) @(posedge CLK100MHZ);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_led", {28'd0, led}, 32'd0);
        ck_rst = 1'b1;
        @(posedge CLK100MHZ); #1;

        // Table of loads/stores, RAM lane steering, errors and LED
        for (int i = 0; i < 22; i++) begin
            do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                   vecs[i].exp_d, vecs[i].exp_e, 1'b1, 0, $sformatf("vec%0d", i), d, v);
            $display("vec%0d we=%0d sz=%0d addr=0x%08h rdata=0x%08h err=%0d",
                     i, vecs[i].we, vecs[i].sz, vecs[i].addr, d, bus.rsp_err);
            if (i == 18) chk("led_after_sw", {28'd0, led}, 32'h5);
        end

        // Byte store to the LED register is legal
        do_req(1'b1, 2'd0, 1'b0, 32'h80000000, 32'h0000001A, 32'h0, 1'b0, 1'b1, 0, "sb_led", d, v);
        chk("led_after_sb", {28'd0, led}, 32'hA);
        do_req(1'b0, 2'd2, 1'b0, 32'h80000000, 32'h0, 32'h0000000A, 1'b0, 1'b1, 0, "lw_led", d, v);
        $display("led sequence led=0x%0h", led);

        // Stalled response: rsp_ready held low for 5 cycles
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234AB01, 1'b0, 1'b1, 5, "stall", d, v);
        $display("stall rdata=0x%08h", d);

        // Counter: two reads differ by elapsed cycles
        do_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 32'h0, 1'b0, 1'b0, 0, "cnt_rd1", d1, v1);
        repeat (7) @(posedge CLK100MHZ);
        #1;
        do_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 32'h0, 1'b0, 1'b0, 0, "cnt_rd2", d2, v2);
        chk("cnt_delta", d2 - d1, 32'(v2 - v1));
        $display("counter reads 0x%08h 0x%08h", d1, d2);

        // Counter clear then immediate read
        do_req(1'b1, 2'd2, 1'b0, 32'h80000004, 32'h12345678, 32'h0, 1'b0, 1'b1, 0, "cnt_clr", d, vs);
        do_req(1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 32'h0, 1'b0, 1'b0, 0, "cnt_rd3", d, v);
        chk("cnt_since_clear", d, 32'(v - 1 - vs));
        $display("counter after clear 0x%08h", d);

        // Reset during WAIT of a store drops the store
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b1, 0, "sw_pre", d, v);
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
        @(posedge CLK100MHZ); #1;
        bus.req_valid = 1'b0;
        @(posedge CLK100MHZ); #1;
        ck_rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("midrst_led", {28'd0, led}, 32'd0);
        @(posedge CLK100MHZ); #1;
        ck_rst = 1'b1;
        @(posedge CLK100MHZ); #1;
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b1, 0, "lw_after_rst", d, v);
        $display("reset mid-op: lw 0x20 = 0x%08h", d);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
